// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Imported by the multiplier controller.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int        MUL_WIDTH     = 8;
    localparam logic [2:0] MUL_ITER_LAST = 3'd7;
    localparam int        PROD_WIDTH    = 16;

endpackage

// File: rtl/eightBitAdder.sv
// Eight-bit ripple-carry adder with carry in/out and signed overflow flag.
// Shared datapath block reused by the multiplier controller.
module eightBitAdder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out,
    output logic       overflow
);

    // Ripple the carry through eight full-adder cells.
    always_comb begin
        logic [8:0] c;
        c      = '0;
        c[0]   = c_in;
        sum    = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        c_out    = c[8];
        overflow = c[7] ^ c[8];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier: eight shift-and-add steps through
// one shared eightBitAdder, with a one-cycle done pulse on completion.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t                  state_q, state_d;
    logic [2:0]              count_q, count_d;
    logic [MUL_WIDTH-1:0]    mcand_q, mcand_d;
    logic [MUL_WIDTH-1:0]    acc_hi_q, acc_hi_d;
    logic [MUL_WIDTH-1:0]    acc_lo_q, acc_lo_d;
    logic [PROD_WIDTH-1:0]   product_q, product_d;

    logic [MUL_WIDTH-1:0]    add_y;
    logic [MUL_WIDTH-1:0]    add_sum;
    logic                    add_cout;
    logic                    adder_ovf_unused;

    // Partial product: add the multiplicand only when the current
    // multiplier bit (LSB of the low accumulator) is set.
    assign add_y = acc_lo_q[0] ? mcand_q : '0;

    eightBitAdder u_adder (
        .x        (acc_hi_q),
        .y        (add_y),
        .c_in     (1'b0),
        .sum      (add_sum),
        .c_out    (add_cout),
        .overflow (adder_ovf_unused)
    );

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, pulse in DONE.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    count_d  = '0;
                end
            end
            RUN: begin
                // {c_out, sum, acc_lo} shifted right by one.
                acc_hi_d = {add_cout, add_sum[MUL_WIDTH-1:1]};
                acc_lo_d = {add_sum[0], acc_lo_q[MUL_WIDTH-1:1]};
                count_d  = count_q + 3'd1;
                if (count_q == MUL_ITER_LAST) begin
                    state_d   = DONE;
                    product_d = {acc_hi_d, acc_lo_d};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: scoreboard of expected
// products pushed on accept and popped when done is observed.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Capture every completed result mid-cycle.
    always @(negedge clk) begin
        if (done) begin
            obs_q.push_back(product);
            done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for IDLE, then issue a one-cycle start; returns just after E0.
    task automatic accept(input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(16'(x) * 16'(y));
        step();
        start = 1'b0;
    endtask

    // Count edges after E0 until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        step();
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        tests++;
        if (product !== 16'h0000) begin
            fails++;
            $display("FAIL reset_product got=%h exp=0000", product);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bit          early;
        logic [15:0] e, o;
        accept(8'h0F, 8'h0F);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy_rise got=%b exp=1", busy);
        end
        early = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (done !== 1'b0) early = 1'b1;
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL basic_done_early got=1 exp=0");
        end
        step();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL basic_done_e8 got=%b exp=1", done);
        end
        @(negedge clk);
        #1;
        tests++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL basic_product got=none exp=00e1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e) begin
                fails++;
                $display("FAIL basic_product got=%h exp=%h", o, e);
            end
        end
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_e9 got busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_max();
        int          lat;
        logic [15:0] e, o;
        accept(8'hFF, 8'hFF);
        wait_done(lat);
        @(negedge clk);
        #1;
        tests++;
        if (lat != 8) begin
            fails++;
            $display("FAIL max_latency got=%0d exp=8", lat);
        end
        tests++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL max_product got=none exp=fe01");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e || o !== 16'hFE01) begin
                fails++;
                $display("FAIL max_product got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_zero();
        logic [7:0]  xs[2] = '{8'h5A, 8'h00};
        logic [7:0]  ys[2] = '{8'h00, 8'hA5};
        int          lat;
        logic [15:0] e, o;
        for (int k = 0; k < 2; k++) begin
            accept(xs[k], ys[k]);
            wait_done(lat);
            @(negedge clk);
            #1;
            tests++;
            if (lat != 8) begin
                fails++;
                $display("FAIL zero_latency_%0d got=%0d exp=8", k, lat);
            end
            tests++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                fails++;
                $display("FAIL zero_product_%0d got=none exp=0000", k);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL zero_product_%0d got=%h exp=%h", k, o, e);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int          base;
        logic [15:0] e, o;
        base = done_cnt;
        accept(8'd3, 8'd4);
        step();
        step();
        step();
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL ignore_done_e8 got=%b exp=1", done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_done_start got busy=%b exp=0", busy);
        end
        step();
        step();
        tests++;
        if (busy !== 1'b0 || done_cnt - base != 1) begin
            fails++;
            $display("FAIL ignore_single_done got busy=%b dones=%0d exp=0/1",
                     busy, done_cnt - base);
        end
        tests++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            fails++;
            $display("FAIL ignore_product got=%0d results exp=1",
                     obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e || o !== 16'h000C) begin
                fails++;
                $display("FAIL ignore_product got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        int          base, lat;
        logic [15:0] e, o;
        accept(8'h80, 8'h02);
        step();
        step();
        step();
        step();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            fails++;
            $display("FAIL abort_async got busy=%b done=%b prod=%h exp=0/0/0000",
                     busy, done, product);
        end
        exp_q.delete();
        base = done_cnt;
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step();
        tests++;
        if (done_cnt != base || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done got dones=%0d busy=%b exp=0/0",
                     done_cnt - base, busy);
        end
        accept(8'h80, 8'h02);
        wait_done(lat);
        @(negedge clk);
        #1;
        tests++;
        if (lat != 8) begin
            fails++;
            $display("FAIL abort_retry_latency got=%0d exp=8", lat);
        end
        tests++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL abort_retry_product got=none exp=0100");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e || o !== 16'h0100) begin
                fails++;
                $display("FAIL abort_retry_product got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          n, ndone;
        bit          bad_gap;
        logic [15:0] e, o;
        n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        a     = 8'd7;
        b     = 8'd6;
        start = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(16'd42);
        ndone   = 0;
        bad_gap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) begin
                if ((i - 8) % 10 != 0) bad_gap = 1'b1;
                ndone++;
            end
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (ndone != 4 || bad_gap) begin
            fails++;
            $display("FAIL held_cadence got dones=%0d off_grid=%b exp=4/0",
                     ndone, bad_gap);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                fails++;
                $display("FAIL held_product_%0d got=none exp=002a", k);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL held_product_%0d got=%h exp=%h", k, o, e);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
